// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: issues word-aligned fetches to a 1-cycle instruction
// memory and queues {pc, instr} pairs in a small FIFO for the core; flushes on redirect.
module inst_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {BOOT, FETCH, FULL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, resp_pc;
  logic          inflight, drop;
  logic [AW:0]   count, count_nxt, occ, occ_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  entry_t        fifo [DEPTH];
  entry_t        head;

  // A response is kept only if it answers a real request and no redirect has
  // happened in this cycle or the one before (both cases carry old-path data).
  assign pop  = if_valid && if_ready;
  assign push = imem_valid && inflight && !drop && !redirect;

  assign occ     = count + {{AW{1'b0}}, inflight};
  assign occ_nxt = count_nxt + {{AW{1'b0}}, imem_req};

  always_comb begin
    count_nxt = count;
    if (redirect)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= BOOT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = imem_req ? DRAIN : FETCH;
    end else begin
      case (state)
        BOOT:    state_nxt = FETCH;
        FETCH:   if (occ_nxt == FULL_CNT) state_nxt = FULL;
        FULL:    if (occ_nxt < FULL_CNT)  state_nxt = FETCH;
        DRAIN:   state_nxt = FETCH;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = (occ < FULL_CNT);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      drop     <= redirect;
      count    <= count_nxt;
      if (imem_req)
        resp_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'd3;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + 32'd4;
        if (push)     wr_ptr   <= wr_ptr + 1'b1;
        if (pop)      rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      fifo[wr_ptr] <= {resp_pc, imem_rdata};
  end

  assign head     = fifo[rd_ptr];
  assign if_valid = (count != '0);
  assign if_instr = if_valid ? head.instr : 32'd0;
  assign if_pc    = if_valid ? head.pc    : 32'd0;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count == FULL_CNT));
  a_valid_has_req: assert property (@(posedge clk) disable iff (reset)
    imem_valid |-> inflight);

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit: a 1-cycle memory model, a scoreboard of
// expected {pc, instr} pops, and cycle-exact checks of fetch and redirect timing.
module tb_inst_prefetch_unit;
  logic        clk = 1'b0;
  logic        reset, imem_req, if_valid, if_ready, redirect;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr, if_instr, if_pc, redirect_pc;
  logic [31:0] imem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;
  int n_pop  = 0;
  bit mode   = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  inst_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] mem_word(input bit m, input logic [31:0] a);
    return m ? (a ^ 32'hA5A5_0013) : 32'h0000_0013;
  endfunction

  // Instruction memory: answers every request exactly one cycle later.
  always @(posedge clk) begin
    imem_valid <= imem_req;
    imem_rdata <= mem_word(mode, imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && if_valid && if_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_instr", if_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    if_ready = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_t e;
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = mem_word(mode, pc);
      exp_q.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time exceeded limit 20000");
    $fatal(1);
  end

  initial begin
    int p;
    int nreq;
    reset       = 1'b1;
    if_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    // Reset values and boot latency with a stream of NOPs.
    mode = 1'b0;
    do_reset();
    check("rst_imem_req",  32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr,     32'd0);
    check("rst_if_valid",  32'(if_valid), 32'd0);
    check("rst_if_instr",  if_instr,      32'd0);
    check("rst_if_pc",     if_pc,         32'd0);
    if_ready = 1'b1;
    push_stream(32'd0, 16);
    p = n_pop;
    tick(); tick();
    check("boot_not_yet_valid", 32'(if_valid), 32'd0);
    tick();
    check("boot_valid", 32'(if_valid), 32'd1);
    check("boot_pc",    if_pc,         32'd0);
    repeat (7) tick();
    check("stream_pops", 32'(n_pop - p), 32'd7);

    // Core stalls: the FIFO fills with exactly DEPTH requests and the head holds.
    mode = 1'b1;
    do_reset();
    push_stream(32'd0, 16);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) nreq++;
      tick();
    end
    check("fill_req_pulses", 32'(nreq),     32'd4);
    check("full_no_req",     32'(imem_req), 32'd0);
    check("full_head_pc",    if_pc,         32'd0);
    check("full_head_instr", if_instr,      mem_word(1'b1, 32'd0));

    // One pop from full: exactly one refill request, order preserved.
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    check("refill_req",  32'(imem_req), 32'd1);
    check("refill_addr", imem_addr,     32'd16);
    tick();
    check("refill_single", 32'(imem_req), 32'd0);
    check("order_head_pc", if_pc,         32'd4);
    if_ready = 1'b1;
    p = n_pop;
    repeat (8) tick();
    check("drain_pops", 32'(n_pop - p), 32'd8);

    // Redirect to an unaligned target with a request in flight.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    exp_q.delete();
    push_stream(32'h0000_0100, 16);
    check("redir_req",   32'(imem_req), 32'd1);
    check("redir_addr",  imem_addr,     32'h0000_0100);
    check("redir_flush", 32'(if_valid), 32'd0);
    tick();
    check("stale_dropped", 32'(if_valid), 32'd0);
    tick();
    check("redir_valid", 32'(if_valid), 32'd1);
    check("redir_pc",    if_pc,         32'h0000_0100);

    // Back-to-back redirects: only the second target is delivered.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0300;
    check("b2b_first_addr", imem_addr, 32'h0000_0200);
    tick();
    redirect = 1'b0;
    exp_q.delete();
    push_stream(32'h0000_0300, 16);
    check("b2b_addr",  imem_addr,     32'h0000_0300);
    check("b2b_flush", 32'(if_valid), 32'd0);
    tick();
    check("b2b_drop", 32'(if_valid), 32'd0);
    tick();
    check("b2b_valid", 32'(if_valid), 32'd1);
    check("b2b_pc",    if_pc,         32'h0000_0300);

    // Fetch address wraps from the top of the address space to zero.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    exp_q.delete();
    push_stream(32'hFFFF_FFF8, 16);
    p = n_pop;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr2", imem_addr, 32'h0000_0000);
    repeat (3) tick();
    check("wrap_pops", 32'(n_pop - p), 32'd3);

    if_ready = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
